// File: rtl/uart_telemetry_sender_if.sv
// Sensor-request / TX-FIFO push bundle for uart_telemetry_sender.
// The slave modport is the formatter; the master modport is the sensor/FIFO side.
interface uart_telemetry_sender_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 14
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]        i_req;
  logic [NUM_CH*DATA_W-1:0] i_data;
  logic                     i_tx_full;
  logic                     o_push;
  logic [7:0]               o_push_data;
  logic                     o_busy;
  logic [CH_W-1:0]          o_active_ch;

  modport master (
    output i_req, i_data, i_tx_full,
    input  o_push, o_push_data, o_busy, o_active_ch
  );

  modport slave (
    input  i_req, i_data, i_tx_full,
    output o_push, o_push_data, o_busy, o_active_ch
  );
endinterface

// File: rtl/uart_telemetry_sender.sv
// Multi-channel ASCII line formatter: round-robin request capture, serial
// double-dabble conversion and "<LABEL>:<digits>\n" pushes into a TX FIFO.
module uart_telemetry_sender #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 14,
  parameter int DIGITS    = 4,
  parameter int LABEL_LEN = 8,
  parameter logic [NUM_CH*LABEL_LEN*8-1:0] LABELS = {NUM_CH*LABEL_LEN{8'h20}},
  parameter logic [NUM_CH*4-1:0]           DP_POS = {NUM_CH{4'd0}}
) (
  input logic clk,
  input logic rst,
  uart_telemetry_sender_if.slave bus
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BCD_W  = 4 * (DIGITS + 1);
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int LIDX_W = (LABEL_LEN > 1) ? $clog2(LABEL_LEN) : 1;
  localparam int DIDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [2:0] {IDLE, CONV, LABEL, COLON, DIGIT, NL} state_t;

  state_t              state, state_n;
  logic [NUM_CH-1:0]   pending, pending_n;
  logic [CH_W-1:0]     last_ch, last_n, active_ch, active_n, winner;
  logic [DATA_W-1:0]   snap, snap_n;
  logic [BCD_W-1:0]    bcd, bcd_n, bcd_adj;
  logic                ovf, ovf_n, dot_now, dot_n, push, sat;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [LIDX_W-1:0]   lbl_idx, lbl_idx_n;
  logic [DIDX_W-1:0]   dig_idx, dig_idx_n;
  logic [LIDX_W:0]     nz_first, nz_next;
  logic [7:0]          byte_out, lbl_byte, digit_byte;
  logic [3:0]          dp_k;

  // Returns {found, index} of the first non-null label byte at or after start.
  function automatic logic [LIDX_W:0] find_nz(input logic [CH_W-1:0] ch, input int start);
    logic [LIDX_W:0] r;
    r = '0;
    for (int j = LABEL_LEN - 1; j >= 0; j--) begin
      if (j >= start && LABELS[(int'(ch) * LABEL_LEN + LABEL_LEN - 1 - j) * 8 +: 8] != 8'h00)
        r = {1'b1, LIDX_W'(j)};
    end
    return r;
  endfunction

  // Round-robin search begins one past the last granted channel.
  always_comb begin
    winner = '0;
    for (int off = NUM_CH; off >= 1; off--) begin
      if (pending[(int'(last_ch) + off) % NUM_CH])
        winner = CH_W'((int'(last_ch) + off) % NUM_CH);
    end
  end

  always_comb begin
    bcd_adj = '0;
    for (int n = 0; n <= DIGITS; n++) begin
      bcd_adj[4*n +: 4] = (bcd[4*n +: 4] >= 4'd5) ? bcd[4*n +: 4] + 4'd3 : bcd[4*n +: 4];
    end
  end

  // A set top nibble or any bit shifted past it means the value exceeds DIGITS digits.
  assign sat        = ovf | (bcd[BCD_W-1 -: 4] != 4'd0);
  assign dp_k       = DP_POS[int'(active_ch) * 4 +: 4];
  assign lbl_byte   = LABELS[(int'(active_ch) * LABEL_LEN + LABEL_LEN - 1 - int'(lbl_idx)) * 8 +: 8];
  assign digit_byte = {4'h3, sat ? 4'd9 : bcd[(DIGITS - 1 - int'(dig_idx)) * 4 +: 4]};
  assign nz_first   = find_nz(active_ch, 0);
  assign nz_next    = find_nz(active_ch, int'(lbl_idx) + 1);

  always_comb begin
    state_n   = state;
    pending_n = pending | bus.i_req;
    last_n    = last_ch;
    active_n  = active_ch;
    snap_n    = snap;
    bcd_n     = bcd;
    ovf_n     = ovf;
    cnt_n     = cnt;
    lbl_idx_n = lbl_idx;
    dig_idx_n = dig_idx;
    dot_n     = dot_now;
    push      = 1'b0;
    byte_out  = 8'h00;
    case (state)
      IDLE: begin
        if (|pending) begin
          pending_n = (pending & ~(NUM_CH'(1) << winner)) | bus.i_req;
          snap_n    = bus.i_data[int'(winner) * DATA_W +: DATA_W];
          active_n  = winner;
          last_n    = winner;
          bcd_n     = '0;
          ovf_n     = 1'b0;
          cnt_n     = '0;
          state_n   = CONV;
        end
      end
      CONV: begin
        bcd_n  = {bcd_adj[BCD_W-2:0], snap[DATA_W-1]};
        ovf_n  = ovf | bcd_adj[BCD_W-1];
        snap_n = snap << 1;
        cnt_n  = cnt + CNT_W'(1);
        if (cnt == CNT_W'(DATA_W - 1)) begin
          if (nz_first[LIDX_W]) begin
            lbl_idx_n = nz_first[LIDX_W-1:0];
            state_n   = LABEL;
          end else begin
            state_n = COLON;
          end
        end
      end
      LABEL: begin
        byte_out = lbl_byte;
        push     = !bus.i_tx_full;
        if (push) begin
          if (nz_next[LIDX_W]) lbl_idx_n = nz_next[LIDX_W-1:0];
          else                 state_n   = COLON;
        end
      end
      COLON: begin
        byte_out = 8'h3A;
        push     = !bus.i_tx_full;
        if (push) begin
          dig_idx_n = '0;
          dot_n     = 1'b0;
          state_n   = DIGIT;
        end
      end
      DIGIT: begin
        byte_out = dot_now ? 8'h2E : digit_byte;
        push     = !bus.i_tx_full;
        if (push) begin
          if (dot_now) begin
            dot_n     = 1'b0;
            dig_idx_n = dig_idx + DIDX_W'(1);
          end else if (dp_k != 4'd0 && int'(dig_idx) == DIGITS - 1 - int'(dp_k)) begin
            dot_n = 1'b1;
          end else if (dig_idx == DIDX_W'(DIGITS - 1)) begin
            state_n = NL;
          end else begin
            dig_idx_n = dig_idx + DIDX_W'(1);
          end
        end
      end
      NL: begin
        byte_out = 8'h0A;
        push     = !bus.i_tx_full;
        if (push) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      last_ch   <= '0;
      active_ch <= '0;
      snap      <= '0;
      bcd       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      lbl_idx   <= '0;
      dig_idx   <= '0;
      dot_now   <= 1'b0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      last_ch   <= last_n;
      active_ch <= active_n;
      snap      <= snap_n;
      bcd       <= bcd_n;
      ovf       <= ovf_n;
      cnt       <= cnt_n;
      lbl_idx   <= lbl_idx_n;
      dig_idx   <= dig_idx_n;
      dot_now   <= dot_n;
    end
  end

  assign bus.o_push      = push;
  assign bus.o_push_data = byte_out;
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_active_ch = active_ch;
endmodule
